// File: rtl/alu_result_queue_if.sv
// alu_result_queue_if: producer/consumer handshake bundle for the ALU result queue
interface alu_result_queue_if #(parameter int DATA_W = 32);
  logic              in_valid;
  logic [DATA_W-1:0] in_y;
  logic [2:0]        in_op;
  logic [3:0]        in_flags;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_y;
  logic [2:0]        out_op;
  logic [3:0]        out_flags;
  modport master (
    output in_valid, in_y, in_op, in_flags, out_ready,
    input  in_ready, out_valid, out_y, out_op, out_flags
  );
  modport slave (
    input  in_valid, in_y, in_op, in_flags, out_ready,
    output in_ready, out_valid, out_y, out_op, out_flags
  );
endinterface

// File: rtl/alu_result_queue.sv
// alu_result_queue: FIFO of ALU results with sticky flag status and saturating drop counter
module alu_result_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_result_queue_if.slave        bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic [3:0]               sticky_flags,
  input  logic                     sticky_clr,
  output logic [7:0]               drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fill_t;
  logic [DATA_W-1:0] mem_y     [DEPTH];
  logic [2:0]        mem_op    [DEPTH];
  logic [3:0]        mem_flags [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  fill_t             fill;
  logic              push, pop, drop;
  // Fill state, handshakes and head outputs decoded from registered count only
  always_comb begin
    fill          = count == '0 ? EMPTY : count == FULL_CNT ? FULL : PARTIAL;
    bus.in_ready  = fill != FULL;
    bus.out_valid = fill != EMPTY;
    push          = bus.in_valid && bus.in_ready;
    pop           = bus.out_valid && bus.out_ready;
    drop          = bus.in_valid && !bus.in_ready;
    bus.out_y     = bus.out_valid ? mem_y[rd_ptr] : '0;
    bus.out_op    = bus.out_valid ? mem_op[rd_ptr] : '0;
    bus.out_flags = bus.out_valid ? mem_flags[rd_ptr] : '0;
  end
  // Entry storage; contents survive reset, only the pointers are cleared
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_y[wr_ptr]     <= bus.in_y;
      mem_op[wr_ptr]    <= bus.in_op;
      mem_flags[wr_ptr] <= bus.in_flags;
    end
  end
  // Pointers, occupancy, sticky flags and drop counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      sticky_flags <= '0;
      drop_cnt     <= '0;
    end else begin
      wr_ptr       <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr       <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count        <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
      sticky_flags <= sticky_clr ? (push ? bus.in_flags : 4'd0) : (push ? sticky_flags | bus.in_flags : sticky_flags);
      drop_cnt     <= sticky_clr ? {7'd0, drop} : (drop && drop_cnt != 8'hFF) ? drop_cnt + 1'b1 : drop_cnt;
    end
  end
endmodule
